muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have exactly one clock and one reset; reset is asynchronous and active-low.
REQ-002 The ports SHALL be as follows, clock and reset first:
- clk_i  in  1  core clock
- rst_ni  in  1  async active-low reset
- start_i  in  1  M-extension op present in Execute (level, held while stalled)
- op_i  in  3  muldiv_op_e (funct3): MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
- operand_a_i  in  32  rs1 value (forwarded)
- operand_b_i  in  32  rs2 value (forwarded)
- flush_i  in  1  kill in-flight op (Execute flush)
- stall_req_o  out  1  to hazard unit exec_stall_req_i
- busy_o  out  1  op in progress (state != IDLE)
- done_o  out  1  result valid this cycle, 1-cycle pulse
- result_o  out  32  rd write data, valid while done_o=1

Function
REQ-003 FSM states SHALL be IDLE, CALC and DONE.
REQ-004 IDLE->CALC SHALL occur on start_i=1 and flush_i=0, latching op_i, operand magnitudes and sign flags, and clearing the iteration counter.
REQ-005 The fast path IDLE->DONE SHALL occur on divide-by-zero (DIV/DIVU/REM/REMU with b=0) or signed overflow (DIV/REM, a=0x80000000, b=0xFFFFFFFF).
REQ-006 CALC SHALL run exactly 32 iterations: a 5-bit counter 0..31, then CALC->DONE.
REQ-007 DONE->IDLE SHALL occur unconditionally after one cycle; start_i is ignored in DONE.
REQ-008 Latency: start accepted at cycle N gives done_o=1 at cycle N+33 on the normal path and N+1 on the fast path.
REQ-009 stall_req_o SHALL be (IDLE & start_i & ~flush_i) | CALC, and SHALL be 0 in DONE so the pipeline advances with result_o.
REQ-010 done_o SHALL be 1 only in DONE; result_o SHALL be 0 when done_o=0.
REQ-011 Multiply SHALL be radix-2 shift-add on 32-bit unsigned magnitudes into a 64-bit product.
- MUL: low word.
- MULH, MULHU, MULHSU: high word.
- Product is negated when the result sign is negative (a signed for MULH/MULHSU, b signed for MULH only).
REQ-012 Divide SHALL be restoring, one quotient bit per iteration, on magnitudes.
- Quotient sign = sa^sb (signed ops only).
- Remainder sign = sa.
REQ-013 Divide-by-zero SHALL give quotient 0xFFFFFFFF and remainder equal to the dividend.
REQ-014 Signed overflow SHALL give quotient 0x80000000 and remainder 0.
REQ-015 flush_i=1 in any state SHALL return to IDLE next cycle with no done_o pulse; flush_i in DONE suppresses done_o that same cycle.
REQ-016 start_i with flush_i in IDLE SHALL NOT start an op.
REQ-017 start_i held high in the cycle after DONE (back-to-back op) SHALL start a new op normally.
REQ-018 Operand and op changes on the inputs during CALC SHALL NOT affect the in-flight op.

Reset
REQ-019 On rst_ni=0 the block SHALL asynchronously go to IDLE with the counter, product, remainder and quotient registers at 0, and stall_req_o=0, busy_o=0, done_o=0, result_o=0.
REQ-020 Reset mid-CALC SHALL abandon the op; no done_o follows reset release.

Structure
REQ-021 muldiv_op_e (3-bit, funct3 encoding) SHALL reside in riscv_types_pkg.
REQ-022 MULDIV_ITERATIONS (=32) SHALL reside in riscv_config_pkg.
REQ-023 The block SHALL be a single module with no sub-modules; multiply and divide share one 64-bit accumulator register and one 33-bit adder/subtractor.
REQ-024 All state SHALL be in one always_ff block with async reset; next-state and datapath logic SHALL be in always_comb.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- MUL a=7, b=0xFFFFFFFD, start at cycle 0 -> stall_req_o=1 cycles 0..32, done_o=1 at cycle 33, result_o=0xFFFFFFEB.
- MULHU a=b=0xFFFFFFFF -> result_o=0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2.
- DIVU a=0x1234, b=0 -> done_o at cycle 1, result_o=0xFFFFFFFF; REM a=0x80000000, b=0xFFFFFFFF -> done_o at cycle 1, result_o=0.
- Flush at cycle 10 of CALC -> IDLE at cycle 11, stall_req_o=0, no done_o; rst_ni low at cycle 5 -> all outputs 0 immediately.
- Back-to-back: second op with start_i held through DONE -> second done_o exactly 34 cycles after the first, with a correct result.

Source files
------------

// File: rtl/riscv_config_pkg.sv
// Core-wide configuration constants.
// MULDIV_ITERATIONS is the number of radix-2 steps of the iterative mul/div unit.
package riscv_config_pkg;

   localparam int unsigned MULDIV_ITERATIONS = 32;

endpackage

// File: rtl/riscv_types_pkg.sv
// Shared RISC-V type definitions used by the execute-stage units.
// muldiv_op_e values follow the M-extension funct3 encoding.
package riscv_types_pkg;

   typedef enum logic [2:0] {
      MD_MUL    = 3'd0,
      MD_MULH   = 3'd1,
      MD_MULHSU = 3'd2,
      MD_MULHU  = 3'd3,
      MD_DIV    = 3'd4,
      MD_DIVU   = 3'd5,
      MD_REM    = 3'd6,
      MD_REMU   = 3'd7
   } muldiv_op_e;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiply and restoring divide; done 33 cycles after start (1 for div-by-zero/overflow).
// Holds the pipeline through stall_req_o while busy; drops the stall in DONE so the result retires with the advancing instruction.
module muldiv_unit
   import riscv_types_pkg::*;
   import riscv_config_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        start_i,
   input  logic [2:0]  op_i,
   input  logic [31:0] operand_a_i,
   input  logic [31:0] operand_b_i,
   input  logic        flush_i,
   output logic        stall_req_o,
   output logic        busy_o,
   output logic        done_o,
   output logic [31:0] result_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam logic [4:0] LAST_ITER = 5'(MULDIV_ITERATIONS - 1);

   state_e      state_q, state_d;
   muldiv_op_e  op_q, op_d;
   logic [63:0] acc_q, acc_d;
   logic [31:0] opb_q, opb_d;
   logic        neg_q, neg_d;
   logic        rneg_q, rneg_d;
   logic [4:0]  cnt_q, cnt_d;

   muldiv_op_e  op_in;
   logic        a_signed, b_signed, sa, sb;
   logic        div_in, div_zero, div_ovf, div_q;
   logic [31:0] mag_a, mag_b;
   logic [32:0] add_x, add_y, add_s;
   logic [63:0] prod;
   logic [31:0] quo, rem, res;

   // Input decode: sign flags and operand magnitudes captured at start.
   always_comb begin
      op_in    = muldiv_op_e'(op_i);
      a_signed = op_in inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
      b_signed = op_in inside {MD_MULH, MD_DIV, MD_REM};
      div_in   = op_in inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
      sa       = a_signed & operand_a_i[31];
      sb       = b_signed & operand_b_i[31];
      mag_a    = sa ? (32'd0 - operand_a_i) : operand_a_i;
      mag_b    = sb ? (32'd0 - operand_b_i) : operand_b_i;
      div_zero = div_in & (operand_b_i == 32'd0);
      div_ovf  = (op_in inside {MD_DIV, MD_REM}) & (operand_a_i == 32'h8000_0000)
                 & (operand_b_i == 32'hFFFF_FFFF);
   end

   // Shared 33-bit adder: adds the multiplicand for multiply, subtracts the divisor for divide.
   always_comb begin
      div_q = op_q inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
      add_x = div_q ? acc_q[63:31] : {1'b0, acc_q[63:32]};
      add_y = {1'b0, opb_q};
      add_s = add_x + (div_q ? ~add_y : add_y) + {32'd0, div_q};
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      acc_d   = acc_q;
      opb_d   = opb_q;
      neg_d   = neg_q;
      rneg_d  = rneg_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (start_i && !flush_i) begin
               op_d   = op_in;
               acc_d  = {32'd0, mag_a};
               opb_d  = mag_b;
               neg_d  = sa ^ sb;
               rneg_d = sa;
               cnt_d  = 5'd0;
               state_d = CALC;
               // Special cases preload the final quotient/remainder and skip iteration.
               if (div_zero) begin
                  acc_d   = {operand_a_i, 32'hFFFF_FFFF};
                  neg_d   = 1'b0;
                  rneg_d  = 1'b0;
                  state_d = DONE;
               end else if (div_ovf) begin
                  acc_d   = {32'd0, 32'h8000_0000};
                  neg_d   = 1'b0;
                  rneg_d  = 1'b0;
                  state_d = DONE;
               end
            end
         end
         CALC: begin
            cnt_d = cnt_q + 5'd1;
            if (div_q) begin
               // Restoring step: keep the difference only when it did not borrow.
               if (!add_s[32]) begin
                  acc_d = {add_s[31:0], acc_q[30:0], 1'b1};
               end else begin
                  acc_d = {acc_q[62:0], 1'b0};
               end
            end else if (acc_q[0]) begin
               acc_d = {add_s, acc_q[31:1]};
            end else begin
               acc_d = {1'b0, acc_q[63:1]};
            end
            if (cnt_q == LAST_ITER) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      if (flush_i) begin
         state_d = IDLE;
      end
   end

   // Sign fix-up of the unsigned magnitude result.
   always_comb begin
      prod = neg_q ? (64'd0 - acc_q) : acc_q;
      quo  = neg_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
      rem  = rneg_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
      res  = 32'd0;
      case (op_q)
         MD_MUL:                       res = prod[31:0];
         MD_MULH, MD_MULHSU, MD_MULHU: res = prod[63:32];
         MD_DIV, MD_DIVU:              res = quo;
         MD_REM, MD_REMU:              res = rem;
         default:                      res = 32'd0;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         op_q    <= MD_MUL;
         acc_q   <= 64'd0;
         opb_q   <= 32'd0;
         neg_q   <= 1'b0;
         rneg_q  <= 1'b0;
         cnt_q   <= 5'd0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         acc_q   <= acc_d;
         opb_q   <= opb_d;
         neg_q   <= neg_d;
         rneg_q  <= rneg_d;
         cnt_q   <= cnt_d;
      end
   end

   assign stall_req_o = ((state_q == IDLE) & start_i & ~flush_i) | (state_q == CALC);
   assign busy_o      = (state_q != IDLE);
   assign done_o      = (state_q == DONE) & ~flush_i;
   assign result_o    = done_o ? res : 32'd0;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed M-extension cases plus randomized ops against an arithmetic reference model.
module tb_muldiv_unit;

   localparam logic [2:0] OP_MUL = 3'd0, OP_MULH = 3'd1, OP_MULHSU = 3'd2, OP_MULHU = 3'd3;
   localparam logic [2:0] OP_DIV = 3'd4, OP_DIVU = 3'd5, OP_REM = 3'd6, OP_REMU = 3'd7;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        start_i = 1'b0;
   logic [2:0]  op_i = 3'd0;
   logic [31:0] operand_a_i = 32'd0;
   logic [31:0] operand_b_i = 32'd0;
   logic        flush_i = 1'b0;
   logic        stall_req_o, busy_o, done_o;
   logic [31:0] result_o;

   muldiv_unit dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .start_i     (start_i),
      .op_i        (op_i),
      .operand_a_i (operand_a_i),
      .operand_b_i (operand_b_i),
      .flush_i     (flush_i),
      .stall_req_o (stall_req_o),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .result_o    (result_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [31:0] res;
      int unsigned cyc;
   } exp_t;

   exp_t        exp_q[$];
   int unsigned done_hist[$];
   int unsigned cyc = 0;
   int unsigned n_cmp = 0;
   int unsigned n_fail = 0;

   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
      longint      sa, sb, ua, ub, q;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'd0, a});
      ub = longint'({32'd0, b});
      p  = 64'd0;
      q  = 0;
      case (op)
         OP_MUL:    begin p = ua * ub; return p[31:0];  end
         OP_MULH:   begin p = sa * sb; return p[63:32]; end
         OP_MULHSU: begin p = sa * ub; return p[63:32]; end
         OP_MULHU:  begin p = ua * ub; return p[63:32]; end
         OP_DIV: begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            q = sa / sb;
            return q[31:0];
         end
         OP_REM: begin
            if (b == 32'd0) return a;
            q = sa % sb;
            return q[31:0];
         end
         OP_DIVU: begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            q = ua / ub;
            return q[31:0];
         end
         default: begin
            if (b == 32'd0) return a;
            q = ua % ub;
            return q[31:0];
         end
      endcase
   endfunction

   function automatic bit is_fast(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      if (op < OP_DIV) return 1'b0;
      if (b == 32'd0) return 1'b1;
      return (op == OP_DIV || op == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'd0;
         1: return 32'd1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'($urandom_range(0, 15));
         5: return 32'h7FFF_FFFF;
         default: return 32'($urandom);
      endcase
   endfunction

   // Scoreboard monitor: every done_o pulse must match the oldest outstanding op.
   always @(negedge clk_i) begin
      if (done_o) begin
         if (exp_q.size() == 0) begin
            check("spurious_done", 32'(done_o), 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("result", result_o, e.res);
            check("done_cycle", 32'(cyc), 32'(e.cyc));
            done_hist.push_back(cyc);
         end
      end else begin
         check("result_zero_idle", result_o, 32'd0);
      end
   end

   task automatic drive_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      start_i     = 1'b1;
      op_i        = op;
      operand_a_i = a;
      operand_b_i = b;
   endtask

   // Called just after a rising edge with the DUT idle; returns just after the edge that leaves DONE.
   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] expv, input bit scramble, input bit chain,
                        input logic [2:0] nop, input logic [31:0] na, input logic [31:0] nb);
      int unsigned lat;
      exp_t        e;
      lat = is_fast(op, a, b) ? 1 : 33;
      drive_op(op, a, b);
      e.res = expv;
      e.cyc = cyc + lat;
      exp_q.push_back(e);
      @(negedge clk_i);
      check("stall_accept", 32'(stall_req_o), 32'd1);
      for (int k = 1; k < int'(lat); k++) begin
         @(posedge clk_i);
         #1;
         if (scramble) drive_op(3'($urandom_range(0, 7)), 32'($urandom), 32'($urandom));
         @(negedge clk_i);
         check("stall_calc", 32'(stall_req_o & busy_o), 32'd1);
      end
      @(posedge clk_i);
      #1;
      if (chain) drive_op(nop, na, nb);
      else       start_i = 1'b0;
      @(negedge clk_i);
      check("stall_done", 32'(stall_req_o), 32'd0);
      check("busy_done", 32'(busy_o), 32'd1);
      @(posedge clk_i);
      #1;
   endtask

   task automatic simple(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expv);
      issue(op, a, b, expv, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
   endtask

   initial begin
      logic [2:0]  cop, nop;
      logic [31:0] ca, cb, na, nb;
      bit          chain;

      repeat (2) @(posedge clk_i);
      #1;
      check("rst_stall", 32'(stall_req_o), 32'd0);
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_done", 32'(done_o), 32'd0);
      check("rst_result", result_o, 32'd0);
      rst_ni = 1'b1;
      @(posedge clk_i);
      #1;

      simple(OP_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB);
      simple(OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE);
      simple(OP_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000);
      simple(OP_MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF);
      simple(OP_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD);
      simple(OP_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF);
      simple(OP_DIVU,   32'd100,        32'd7,         32'd14);
      simple(OP_REMU,   32'd100,        32'd7,         32'd2);
      simple(OP_DIVU,   32'h1234,       32'd0,         32'hFFFF_FFFF);
      simple(OP_REMU,   32'h1234,       32'd0,         32'h1234);
      simple(OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0);
      simple(OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000);

      // Back-to-back with start held through DONE.
      issue(OP_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 1'b1, OP_DIVU, 32'd100, 32'd7);
      simple(OP_DIVU, 32'd100, 32'd7, 32'd14);
      if (done_hist.size() >= 2)
         check("b2b_spacing", done_hist[$] - done_hist[$-1], 32'd34);
      else
         check("b2b_done_count", 32'(done_hist.size()), 32'd2);

      // Start together with flush in IDLE must not launch an op.
      drive_op(OP_MUL, 32'd3, 32'd4);
      flush_i = 1'b1;
      @(negedge clk_i);
      check("flush_idle_stall", 32'(stall_req_o), 32'd0);
      @(posedge clk_i);
      #1;
      start_i = 1'b0;
      flush_i = 1'b0;
      @(negedge clk_i);
      check("flush_idle_busy", 32'(busy_o), 32'd0);

      // Flush mid-CALC: back to IDLE next cycle, no done pulse afterwards.
      @(posedge clk_i);
      #1;
      drive_op(OP_MUL, 32'($urandom), 32'($urandom));
      repeat (10) begin
         @(posedge clk_i);
         #1;
      end
      flush_i = 1'b1;
      start_i = 1'b0;
      @(posedge clk_i);
      #1;
      flush_i = 1'b0;
      @(negedge clk_i);
      check("flush_calc_busy", 32'(busy_o), 32'd0);
      check("flush_calc_stall", 32'(stall_req_o), 32'd0);
      repeat (40) @(posedge clk_i);
      #1;

      // Flush in DONE suppresses that cycle's pulse.
      drive_op(OP_DIVU, 32'd5, 32'd0);
      @(posedge clk_i);
      #1;
      start_i = 1'b0;
      flush_i = 1'b1;
      @(negedge clk_i);
      check("flush_done_pulse", 32'(done_o), 32'd0);
      @(posedge clk_i);
      #1;
      flush_i = 1'b0;
      @(negedge clk_i);
      check("flush_done_busy", 32'(busy_o), 32'd0);

      // Reset mid-CALC clears outputs immediately and abandons the op.
      @(posedge clk_i);
      #1;
      drive_op(OP_DIVU, 32'($urandom), 32'd3);
      repeat (5) begin
         @(posedge clk_i);
         #1;
      end
      rst_ni  = 1'b0;
      start_i = 1'b0;
      #1;
      check("rst_mid_stall", 32'(stall_req_o), 32'd0);
      check("rst_mid_busy", 32'(busy_o), 32'd0);
      check("rst_mid_done", 32'(done_o), 32'd0);
      check("rst_mid_result", result_o, 32'd0);
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      repeat (40) @(posedge clk_i);
      #1;

      // Randomized ops, operands scrambled during CALC, random back-to-back chaining.
      nop = 3'($urandom_range(0, 7));
      na  = pick();
      nb  = pick();
      for (int i = 0; i < 60; i++) begin
         cop = nop;
         ca  = na;
         cb  = nb;
         nop = 3'($urandom_range(0, 7));
         na  = pick();
         nb  = pick();
         chain = (i != 59) && ($urandom_range(0, 1) == 1);
         issue(cop, ca, cb, ref_model(cop, ca, cb), 1'b1, chain, nop, na, nb);
         if (!chain) begin
            repeat ($urandom_range(0, 3)) @(posedge clk_i);
            #1;
         end
      end

      repeat (5) @(posedge clk_i);
      #1;
      check("pending_results", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
